// File: rtl/brick_arbiter.sv
// Arbitrates renderer reads, ball-hit read-modify-write updates and level loads onto one
// single-port brick RAM. Define BRICK_ARB_STARVE_GUARD_EN to stop reads starving updates.
module brick_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data,
  output logic          rd_valid,
  input  logic          upd_req,
  input  logic [AW-1:0] upd_addr,
  output logic          upd_ack,
  output logic [1:0]    upd_old,
  input  logic          load_req,
  input  logic [2:0]    load_level,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata,
  output logic [AW:0]   bricks_left
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RMW_RD = 2'd1;
  localparam logic [1:0] RMW_WR = 2'd2;
  localparam logic [1:0] LOAD   = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST_NEXT  = AW'(1);
  localparam logic [AW:0]   BRICKS_FULL = (AW + 1)'(DEPTH);

  // Brick strength for a cell: cycles 1,2,3 along the address, rotated by the level.
  function automatic logic [1:0] level_value(input logic [2:0] addr_lo, input logic [2:0] level);
    logic [3:0] sum;
    sum = {1'b0, addr_lo} + {1'b0, level};
    return 2'(sum % 4'd3) + 2'd1;
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    nxt_state_s;
  logic [AW-1:0] load_cnt_r;
  logic [2:0]    level_r;
  logic          rd_valid_r;
  logic          load_done_r;
  logic [AW:0]   bricks_left_r;

  logic idle_s;
  logic upd_first_s;
  logic grant_load_s;
  logic grant_rd_s;
  logic grant_upd_s;
  logic load_last_s;

  assign idle_s       = rst && (state_r == IDLE);
  assign grant_load_s = idle_s && load_req;
  assign grant_rd_s   = idle_s && !load_req && rd_req && !upd_first_s;
  assign grant_upd_s  = idle_s && !load_req && upd_req && (!rd_req || upd_first_s);
  assign load_last_s  = (state_r == LOAD) && (load_cnt_r == LAST_ADDR);

`ifdef BRICK_ARB_STARVE_GUARD_EN
  logic [4:0] starve_cnt_r;

  assign upd_first_s = upd_req && (starve_cnt_r == 5'd16);

  // Counts consecutive IDLE cycles in which a pending update lost arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= 5'd0;
    end else if (state_r == IDLE) begin
      if (!upd_req || grant_upd_s) begin
        starve_cnt_r <= 5'd0;
      end else if (starve_cnt_r != 5'd16) begin
        starve_cnt_r <= starve_cnt_r + 5'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign upd_first_s = 1'b0;
`endif

  // RAM port, handshake pulses and next state; everything is forced quiet while rst is low.
  always_comb begin
    nxt_state_s = state_r;
    mem_addr    = {AW{1'b0}};
    mem_we      = 1'b0;
    mem_wdata   = 2'd0;
    upd_ack     = 1'b0;
    upd_old     = 2'd0;
    load_busy   = 1'b0;
    if (rst) begin
      case (state_r)
        IDLE: begin
          if (grant_load_s) begin
            nxt_state_s = LOAD;
            load_busy   = 1'b1;
            mem_we      = 1'b1;
            mem_wdata   = level_value(3'd0, load_level);
          end else if (grant_rd_s) begin
            mem_addr = rd_addr;
          end else if (grant_upd_s) begin
            nxt_state_s = RMW_RD;
          end else begin
            nxt_state_s = IDLE;
          end
        end
        RMW_RD: begin
          mem_addr    = upd_addr;
          nxt_state_s = RMW_WR;
        end
        RMW_WR: begin
          mem_addr = upd_addr;
          upd_ack  = 1'b1;
          upd_old  = mem_rdata;
          if (mem_rdata != 2'd0) begin
            mem_we    = 1'b1;
            mem_wdata = mem_rdata - 2'd1;
          end else begin
            mem_we    = 1'b0;
            mem_wdata = 2'd0;
          end
          nxt_state_s = IDLE;
        end
        LOAD: begin
          load_busy = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = load_cnt_r;
          mem_wdata = level_value(load_cnt_r[2:0], level_r);
          if (load_last_s) begin
            nxt_state_s = IDLE;
          end else begin
            nxt_state_s = LOAD;
          end
        end
        default: begin
          nxt_state_s = IDLE;
        end
      endcase
    end else begin
      nxt_state_s = IDLE;
    end
  end

  // State, load sequencing, read-valid and live brick count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      load_cnt_r    <= {AW{1'b0}};
      level_r       <= 3'd0;
      rd_valid_r    <= 1'b0;
      load_done_r   <= 1'b0;
      bricks_left_r <= {(AW + 1){1'b0}};
    end else begin
      state_r     <= nxt_state_s;
      rd_valid_r  <= grant_rd_s;
      load_done_r <= load_last_s;
      if (grant_load_s) begin
        load_cnt_r <= FIRST_NEXT;
        level_r    <= load_level;
      end else if (state_r == LOAD) begin
        load_cnt_r <= load_cnt_r + FIRST_NEXT;
      end else begin
        load_cnt_r <= load_cnt_r;
      end
      // A brick only disappears when a hit takes it from strength 1 to 0.
      if (load_last_s) begin
        bricks_left_r <= BRICKS_FULL;
      end else if ((state_r == RMW_WR) && (mem_rdata == 2'd1) &&
                   (bricks_left_r != {(AW + 1){1'b0}})) begin
        bricks_left_r <= bricks_left_r - {{AW{1'b0}}, 1'b1};
      end else begin
        bricks_left_r <= bricks_left_r;
      end
    end
  end

  assign rd_valid    = rd_valid_r;
  assign rd_data     = rd_valid_r ? mem_rdata : 2'd0;
  assign load_done   = load_done_r;
  assign bricks_left = bricks_left_r;

endmodule

// File: tb/tb_brick_arbiter.sv
// Directed bench for brick_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_brick_arbiter;

  logic       clk;
  logic       rst;
  logic       rd_req;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       rd_valid;
  logic       upd_req;
  logic [5:0] upd_addr;
  logic       upd_ack;
  logic [1:0] upd_old;
  logic       load_req;
  logic [2:0] load_level;
  logic       load_busy;
  logic       load_done;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic [6:0] bricks_left;

  int tests;
  int fails;

  logic [1:0] ram [0:63];

  brick_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .upd_req     (upd_req),
    .upd_addr    (upd_addr),
    .upd_ack     (upd_ack),
    .upd_old     (upd_old),
    .load_req    (load_req),
    .load_level  (load_level),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .bricks_left (bricks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_val(input int a, input int lvl);
    return 1 + (((a % 8) + lvl) % 3);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_data"},   32'(rd_data),     32'd0);
    chk({tag, "_rd_valid"},  32'(rd_valid),    32'd0);
    chk({tag, "_upd_ack"},   32'(upd_ack),     32'd0);
    chk({tag, "_upd_old"},   32'(upd_old),     32'd0);
    chk({tag, "_load_busy"}, 32'(load_busy),   32'd0);
    chk({tag, "_load_done"}, 32'(load_done),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),      32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),    32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata),   32'd0);
    chk({tag, "_bricks"},    32'(bricks_left), 32'd0);
  endtask

  task automatic run_load(input int lvl);
    load_req = 1'b1;
    load_level = 3'(lvl);
    #1;
    chk("load_grant_busy", 32'(load_busy), 32'd1);
    chk("load_grant_we", 32'(mem_we), 32'd1);
    chk("load_grant_addr", 32'(mem_addr), 32'd0);
    chk("load_grant_wdata", 32'(mem_wdata), 32'(exp_val(0, lvl)));
    tick();
    for (int i = 1; i < 64; i++) begin
      load_req = (i < 10);
      #1;
      chk("load_busy", 32'(load_busy), 32'd1);
      chk("load_addr", 32'(mem_addr), 32'(i));
      chk("load_wdata", 32'(mem_wdata), 32'(exp_val(i, lvl)));
      chk("load_done_early", 32'(load_done), 32'd0);
      tick();
    end
    load_req = 1'b0;
    #1;
    chk("load_busy_end", 32'(load_busy), 32'd0);
    chk("load_done_pulse", 32'(load_done), 32'd1);
    chk("load_bricks_full", 32'(bricks_left), 32'd64);
    tick();
    chk("load_done_single", 32'(load_done), 32'd0);
    tick();
  endtask

  task automatic do_read(input int a, input int exp);
    rd_req = 1'b1;
    rd_addr = 6'(a);
    #1;
    chk("rd_grant_addr", 32'(mem_addr), 32'(a));
    chk("rd_grant_we", 32'(mem_we), 32'd0);
    chk("rd_valid_before", 32'(rd_valid), 32'd0);
    tick();
    rd_req = 1'b0;
    #1;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", 32'(rd_data), 32'(exp));
    tick();
  endtask

  task automatic do_update(input int a, input int exp_old, input int exp_bricks);
    upd_req = 1'b1;
    upd_addr = 6'(a);
    #1;
    chk("upd_grant_we", 32'(mem_we), 32'd0);
    chk("upd_grant_ack", 32'(upd_ack), 32'd0);
    tick();
    chk("rmw_rd_addr", 32'(mem_addr), 32'(a));
    chk("rmw_rd_we", 32'(mem_we), 32'd0);
    chk("rmw_rd_ack", 32'(upd_ack), 32'd0);
    tick();
    chk("rmw_wr_ack", 32'(upd_ack), 32'd1);
    chk("rmw_wr_old", 32'(upd_old), 32'(exp_old));
    chk("rmw_wr_we", 32'(mem_we), (exp_old != 0) ? 32'd1 : 32'd0);
    chk("rmw_wr_wdata", 32'(mem_wdata), (exp_old != 0) ? 32'(exp_old - 1) : 32'd0);
    upd_req = 1'b0;
    tick();
    chk("upd_ack_single", 32'(upd_ack), 32'd0);
    chk("upd_bricks", 32'(bricks_left), 32'(exp_bricks));
    tick();
  endtask

  initial begin
    int ack_at;
    int valid_cnt;
    int late_ack;
    int done_cnt;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    rd_req = 1'b0;
    rd_addr = 6'd0;
    upd_req = 1'b0;
    upd_addr = 6'd0;
    load_req = 1'b0;
    load_level = 3'd0;
    #1;
    chk_quiet("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_quiet("idle");

    run_load(0);
    do_read(0, 1);
    do_read(1, 2);
    do_read(2, 3);
    do_read(5, 3);

    do_update(0, 1, 63);
    do_read(0, 0);
    do_update(0, 0, 63);

    // Read and update collide: read wins, update follows; a read during RMW is dropped.
    rd_req = 1'b1;
    rd_addr = 6'd1;
    upd_req = 1'b1;
    upd_addr = 6'd2;
    #1;
    chk("collide_rd_addr", 32'(mem_addr), 32'd1);
    chk("collide_ack", 32'(upd_ack), 32'd0);
    tick();
    rd_req = 1'b0;
    #1;
    chk("collide_rd_valid", 32'(rd_valid), 32'd1);
    chk("collide_rd_data", 32'(rd_data), 32'd2);
    chk("collide_upd_grant_we", 32'(mem_we), 32'd0);
    tick();
    rd_req = 1'b1;
    rd_addr = 6'd6;
    #1;
    chk("collide_rmw_rd_addr", 32'(mem_addr), 32'd2);
    tick();
    rd_req = 1'b0;
    #1;
    chk("collide_ack_pulse", 32'(upd_ack), 32'd1);
    chk("collide_old", 32'(upd_old), 32'd3);
    chk("collide_wdata", 32'(mem_wdata), 32'd2);
    chk("collide_rd_dropped", 32'(rd_valid), 32'd0);
    upd_req = 1'b0;
    tick();
    chk("collide_no_late_valid", 32'(rd_valid), 32'd0);
    chk("collide_bricks", 32'(bricks_left), 32'd63);
    tick();

    // Continuous reads against a pending update on cell 3 (strength 1).
    rd_req = 1'b1;
    rd_addr = 6'd7;
    upd_req = 1'b1;
    upd_addr = 6'd3;
    ack_at = -1;
    valid_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (i > 0 && rd_valid === 1'b1) valid_cnt++;
      if (upd_ack === 1'b1 && ack_at < 0) begin
        ack_at = i;
        upd_req = 1'b0;
      end
      tick();
    end
    rd_req = 1'b0;
`ifdef BRICK_ARB_STARVE_GUARD_EN
    chk("starve_ack_cycle", 32'(ack_at), 32'd18);
    chk("starve_rd_valid_cnt", 32'(valid_cnt), 32'd96);
`else
    chk("starve_no_ack", 32'(ack_at), 32'hFFFF_FFFF);
    chk("starve_rd_valid_cnt", 32'(valid_cnt), 32'd99);
`endif
    late_ack = 0;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (upd_ack === 1'b1) begin
        late_ack++;
        upd_req = 1'b0;
      end
      tick();
    end
`ifdef BRICK_ARB_STARVE_GUARD_EN
    chk("starve_no_extra_ack", 32'(late_ack), 32'd0);
`else
    chk("starve_late_ack", 32'(late_ack), 32'd1);
`endif
    chk("starve_bricks", 32'(bricks_left), 32'd62);
    do_read(3, 0);

    // Level-1 load cut short by reset at cell 30, with reads held against it.
    rd_req = 1'b1;
    rd_addr = 6'd9;
    load_req = 1'b1;
    load_level = 3'd1;
    #1;
    chk("load1_grant_busy", 32'(load_busy), 32'd1);
    chk("load1_grant_addr", 32'(mem_addr), 32'd0);
    chk("load1_grant_wdata", 32'(mem_wdata), 32'(exp_val(0, 1)));
    tick();
    load_req = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      #1;
      chk("load1_addr", 32'(mem_addr), 32'(i));
      chk("load1_wdata", 32'(mem_wdata), 32'(exp_val(i, 1)));
      chk("load1_no_rd_valid", 32'(rd_valid), 32'd0);
      if (i < 30) tick();
    end
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid_load");
    rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (load_done === 1'b1) done_cnt++;
      tick();
    end
    chk("post_rst_no_load_done", 32'(done_cnt), 32'd0);
    chk("post_rst_busy", 32'(load_busy), 32'd0);
    chk("post_rst_bricks", 32'(bricks_left), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
